// File: rtl/axicb_scfifo_ctrl_if.sv
// Push/pull handshake bundle for axicb_scfifo_ctrl.
// slave: the FIFO controller side; master: the producer/consumer side.
interface axicb_scfifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/axicb_scfifo_ctrl.sv
// Single-clock FIFO controller driving an external axicb_scfifo_ram; FFD_EN=1 adds a 2-entry prefetch stage.
// Optional macro AXICB_SCFIFO_LEVEL_EN enables the registered occupancy counter on `level`.
module axicb_scfifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FFD_EN     = 0
) (
    input  logic                  aclk,
    input  logic                  srst,
    axicb_scfifo_ctrl_if.slave    bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH+1:0] level
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] ram_cnt;
    logic                full;
    logic                ram_empty;
    logic                push;
    logic                pop;
    logic                rd_adv;

    // The extra wrap bit keeps full (cnt==DEPTH) and empty (cnt==0) distinct.
    assign ram_cnt   = wr_ptr_q - rd_ptr_q;
    assign full      = (ram_cnt == DEPTH);
    assign ram_empty = (ram_cnt == '0);

    assign bus.in_ready = !full && !srst;
    assign push         = bus.in_valid && bus.in_ready;
    assign ram_wr_en    = push;
    assign ram_addr_in  = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_in  = bus.in_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(push);
        rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(rd_adv);
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    if (FFD_EN == 0) begin : g_direct
        assign bus.out_valid = !ram_empty;
        assign bus.out_data  = ram_data_out;
        assign ram_addr_out  = rd_ptr_q[ADDR_WIDTH-1:0];
        assign pop           = bus.out_valid && bus.out_ready;
        assign rd_adv        = pop;
    end else begin : g_prefetch
        logic [DATA_WIDTH-1:0] stg_q [2];
        logic [DATA_WIDTH-1:0] stg_d [2];
        logic [1:0]            stg_cnt_q, stg_cnt_d;
        logic                  inflight_q;
        logic [ADDR_WIDTH-1:0] raddr_q;
        logic [2:0]            occ;
        logic                  issue;
        logic                  tail_idx;

        assign pop  = (stg_cnt_q != 2'd0) && bus.out_ready;
        // Stage slots already claimed after this cycle's pop; a new read may only fill a free one.
        assign occ   = 3'(stg_cnt_q) + 3'(inflight_q) - 3'(pop);
        assign issue = !ram_empty && (occ < 3'd2);

        assign rd_adv        = issue;
        assign bus.out_valid = (stg_cnt_q != 2'd0);
        assign bus.out_data  = stg_q[0];
        assign ram_addr_out  = issue ? rd_ptr_q[ADDR_WIDTH-1:0] : raddr_q;

        always_comb begin
            stg_d     = stg_q;
            stg_cnt_d = stg_cnt_q - 2'(pop) + 2'(inflight_q);
            tail_idx  = ((stg_cnt_q - 2'(pop)) != 2'd0);
            if (pop) begin
                stg_d[0] = stg_q[1];
            end
            if (inflight_q) begin
                stg_d[tail_idx] = ram_data_out;
            end
        end

        // A read outstanding at reset is dropped: inflight_q clears, so its data never lands.
        always_ff @(posedge aclk) begin
            if (srst) begin
                stg_cnt_q  <= '0;
                inflight_q <= 1'b0;
                raddr_q    <= '0;
            end else begin
                stg_cnt_q  <= stg_cnt_d;
                inflight_q <= issue;
                if (issue) begin
                    raddr_q <= rd_ptr_q[ADDR_WIDTH-1:0];
                end
            end
            stg_q <= stg_d;
        end
    end

`ifdef AXICB_SCFIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] level_q, level_d;

    always_comb begin
        level_d = level_q + (ADDR_WIDTH+2)'(push) - (ADDR_WIDTH+2)'(pop);
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_axicb_scfifo_ctrl.sv
// Bench for axicb_scfifo_ctrl: one instance per FFD_EN setting, each with its own RAM model.
// Level expectations follow AXICB_SCFIFO_LEVEL_EN as seen by the bench build.
module tb_axicb_scfifo_ctrl;

`ifdef AXICB_SCFIFO_LEVEL_EN
    localparam bit LVL_ON = 1'b1;
`else
    localparam bit LVL_ON = 1'b0;
`endif

    logic clk;
    logic srst0, srst1;

    logic       wr_en0, wr_en1;
    logic [1:0] waddr0, waddr1, raddr0, raddr1;
    logic [7:0] wdata0, wdata1, rdata0, rdata1;
    logic [3:0] level0, level1;
    logic [7:0] mem0 [4];
    logic [7:0] mem1 [4];

    int n_chk = 0;
    int n_err = 0;

    axicb_scfifo_ctrl_if #(.DATA_WIDTH(8)) bus0 ();
    axicb_scfifo_ctrl_if #(.DATA_WIDTH(8)) bus1 ();

    axicb_scfifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(0)) u_dut0 (
        .aclk(clk), .srst(srst0), .bus(bus0),
        .ram_wr_en(wr_en0), .ram_addr_in(waddr0), .ram_data_in(wdata0),
        .ram_addr_out(raddr0), .ram_data_out(rdata0), .level(level0)
    );

    axicb_scfifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(1)) u_dut1 (
        .aclk(clk), .srst(srst1), .bus(bus1),
        .ram_wr_en(wr_en1), .ram_addr_in(waddr1), .ram_data_in(wdata1),
        .ram_addr_out(raddr1), .ram_data_out(rdata1), .level(level1)
    );

    // RAM models: asynchronous read for FFD_EN=0, registered read for FFD_EN=1
    always_ff @(posedge clk) if (wr_en0) mem0[waddr0] <= wdata0;
    assign rdata0 = mem0[raddr0];
    always_ff @(posedge clk) begin
        if (wr_en1) mem1[waddr1] <= wdata1;
        rdata1 <= mem1[raddr1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q0 [$];
    int         wr0;
    logic [7:0] rq1 [$];
    logic [7:0] sq1 [$];
    bit         infl1;
    logic [7:0] infl_d1;
    int         wr1;

    typedef struct {
        bit         iv;
        logic [7:0] d;
        bit         orr;
        bit         ir;
        bit         ov;
        logic [7:0] od;
        int         lvl;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        srst0 = 1'b1; srst1 = 1'b1;
        idle_inputs();
        bus0.in_valid = 1'b1; bus1.in_valid = 1'b1;
        next_cyc();
        next_cyc();
        #2;
        chk("rst0_in_ready", bus0.in_ready, 0);
        chk("rst0_out_valid", bus0.out_valid, 0);
        chk("rst0_wr_en", wr_en0, 0);
        chk("rst0_level", level0, 0);
        chk("rst0_addr_in", waddr0, 0);
        chk("rst0_addr_out", raddr0, 0);
        chk("rst1_in_ready", bus1.in_ready, 0);
        chk("rst1_out_valid", bus1.out_valid, 0);
        chk("rst1_wr_en", wr_en1, 0);
        chk("rst1_level", level1, 0);
        chk("rst1_addr_in", waddr1, 0);
        chk("rst1_addr_out", raddr1, 0);
        srst0 = 1'b0; srst1 = 1'b0;
        idle_inputs();
        #1;
        chk("rst0_in_ready_rise", bus0.in_ready, 1);
        chk("rst1_in_ready_rise", bus1.in_ready, 1);
        q0.delete(); wr0 = 0;
        rq1.delete(); sq1.delete(); infl1 = 0; infl_d1 = '0; wr1 = 0;
        next_cyc();
    endtask

    // Compare both DUTs with the model for the current cycle, then advance the model over the edge.
    task automatic model_cycle();
        bit e_ir, e_ov, pop, iss;
        int occ;
        e_ir = !srst0 && (q0.size() < 4);
        e_ov = (q0.size() != 0);
        chk("m0_in_ready", bus0.in_ready, e_ir);
        chk("m0_out_valid", bus0.out_valid, e_ov);
        if (e_ov) chk("m0_out_data", bus0.out_data, q0[0]);
        chk("m0_wr_en", wr_en0, bus0.in_valid && e_ir);
        chk("m0_addr_in", waddr0, wr0 % 4);
        chk("m0_wdata", wdata0, bus0.in_data);
        chk("m0_level", level0, LVL_ON ? q0.size() : 0);
        if (srst0) begin
            q0.delete(); wr0 = 0;
        end else begin
            if (e_ov && bus0.out_ready) void'(q0.pop_front());
            if (bus0.in_valid && e_ir) begin q0.push_back(bus0.in_data); wr0++; end
        end

        e_ir = !srst1 && (rq1.size() < 4);
        e_ov = (sq1.size() != 0);
        chk("m1_in_ready", bus1.in_ready, e_ir);
        chk("m1_out_valid", bus1.out_valid, e_ov);
        if (e_ov) chk("m1_out_data", bus1.out_data, sq1[0]);
        chk("m1_wr_en", wr_en1, bus1.in_valid && e_ir);
        chk("m1_addr_in", waddr1, wr1 % 4);
        chk("m1_level", level1, LVL_ON ? (rq1.size() + sq1.size() + int'(infl1)) : 0);
        if (srst1) begin
            rq1.delete(); sq1.delete(); infl1 = 0; wr1 = 0;
        end else begin
            pop = e_ov && bus1.out_ready;
            occ = sq1.size() + int'(infl1) - int'(pop);
            iss = (rq1.size() != 0) && (occ < 2);
            if (pop) void'(sq1.pop_front());
            if (infl1) sq1.push_back(infl_d1);
            infl1 = iss;
            if (iss) infl_d1 = rq1.pop_front();
            if (bus1.in_valid && e_ir) begin rq1.push_back(bus1.in_data); wr1++; end
        end
    endtask

    initial begin
        logic [7:0] got [$];
        int acc;
        int p_in;

        // Fill/drain, then full with simultaneous push and pop (FFD_EN=0)
        tbl[0]  = '{1, 8'h11, 0, 1, 0, 8'h00, 0};
        tbl[1]  = '{1, 8'h12, 0, 1, 1, 8'h11, 1};
        tbl[2]  = '{1, 8'h13, 0, 1, 1, 8'h11, 2};
        tbl[3]  = '{1, 8'h14, 0, 1, 1, 8'h11, 3};
        tbl[4]  = '{0, 8'h00, 0, 0, 1, 8'h11, 4};
        tbl[5]  = '{0, 8'h00, 1, 0, 1, 8'h11, 4};
        tbl[6]  = '{0, 8'h00, 1, 1, 1, 8'h12, 3};
        tbl[7]  = '{0, 8'h00, 1, 1, 1, 8'h13, 2};
        tbl[8]  = '{0, 8'h00, 1, 1, 1, 8'h14, 1};
        tbl[9]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0};
        tbl[10] = '{1, 8'h21, 0, 1, 0, 8'h00, 0};
        tbl[11] = '{1, 8'h22, 0, 1, 1, 8'h21, 1};
        tbl[12] = '{1, 8'h23, 0, 1, 1, 8'h21, 2};
        tbl[13] = '{1, 8'h24, 0, 1, 1, 8'h21, 3};
        tbl[14] = '{1, 8'h25, 1, 0, 1, 8'h21, 4};
        tbl[15] = '{0, 8'h00, 0, 1, 1, 8'h22, 3};
        tbl[16] = '{0, 8'h00, 1, 1, 1, 8'h22, 3};
        tbl[17] = '{0, 8'h00, 1, 1, 1, 8'h23, 2};
        tbl[18] = '{0, 8'h00, 1, 1, 1, 8'h24, 1};
        tbl[19] = '{0, 8'h00, 0, 1, 0, 8'h00, 0};

        idle_inputs();
        srst0 = 1'b1; srst1 = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 20; i++) begin
            bus0.in_valid = tbl[i].iv; bus0.in_data = tbl[i].d; bus0.out_ready = tbl[i].orr;
            #2;
            chk($sformatf("t%0d_in_ready", i), bus0.in_ready, tbl[i].ir);
            chk($sformatf("t%0d_out_valid", i), bus0.out_valid, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("t%0d_out_data", i), bus0.out_data, tbl[i].od);
            chk($sformatf("t%0d_wr_en", i), wr_en0, tbl[i].iv && tbl[i].ir);
            chk($sformatf("t%0d_level", i), level0, LVL_ON ? tbl[i].lvl : 0);
            next_cyc();
        end
        idle_inputs();

        // Streaming through the prefetch stage: first word 3 cycles after the first push
        for (int c = 0; c < 41; c++) begin
            bus1.in_valid = (c < 32); bus1.in_data = 8'(c); bus1.out_ready = 1'b1;
            #2;
            if (c < 32) chk("s2_in_ready", bus1.in_ready, 1);
            chk($sformatf("s2_out_valid_c%0d", c), bus1.out_valid, (c >= 3) && (c < 35));
            if ((c >= 3) && (c < 35)) chk("s2_out_data", bus1.out_data, c - 3);
            next_cyc();
        end

        // Capacity with the consumer stalled
        acc = 0;
        for (int c = 0; c < 15; c++) begin
            bus1.in_valid = 1'b1; bus1.in_data = 8'(8'h40 + c); bus1.out_ready = 1'b0;
            #2;
            if (bus1.in_ready) acc++;
            next_cyc();
        end
        bus1.in_valid = 1'b0;
        #2;
        chk("s2_capacity", acc, 6);
        chk("s2_cap_level", level1, LVL_ON ? 6 : 0);
        for (int c = 0; c < 8; c++) begin
            bus1.out_ready = 1'b1;
            #2;
            if (bus1.out_valid) got.push_back(bus1.out_data);
            next_cyc();
        end
        chk("s2_drain_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++) chk("s2_drain_data", got[k], 8'h40 + k);
        bus1.out_ready = 1'b0;

        // Reset while a prefetch read is outstanding
        for (int c = 0; c < 6; c++) begin
            bus1.in_valid = 1'b1; bus1.in_data = 8'(8'h60 + c); bus1.out_ready = 1'b1;
            next_cyc();
        end
        srst1 = 1'b1;
        next_cyc();
        srst1 = 1'b0; bus1.in_valid = 1'b1; bus1.in_data = 8'hA5; bus1.out_ready = 1'b1;
        #2;
        chk("r5_out_valid", bus1.out_valid, 0);
        chk("r5_level", level1, 0);
        chk("r5_in_ready", bus1.in_ready, 1);
        next_cyc();
        bus1.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("r5_out_valid_k%0d", k), bus1.out_valid, k == 2);
            if (k == 2) chk("r5_first_word", bus1.out_data, 8'hA5);
            next_cyc();
        end
        idle_inputs();

        // Wrap-around with occupancy oscillating 0..3, checked against the model
        do_reset();
        for (int c = 0; c < 80; c++) begin
            bus0.in_valid = (c % 6) < 3; bus0.in_data = 8'($urandom_range(0, 255));
            bus0.out_ready = (c % 6) >= 3;
            bus1.in_valid = (c % 8) < 4; bus1.in_data = 8'($urandom_range(0, 255));
            bus1.out_ready = (c % 8) >= 4;
            #2;
            model_cycle();
            next_cyc();
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            p_in = ((c / 60) % 3 == 0) ? 30 : (((c / 60) % 3 == 1) ? 55 : 85);
            srst0 = ($urandom_range(0, 127) == 0);
            srst1 = ($urandom_range(0, 127) == 0);
            bus0.in_valid = ($urandom_range(0, 99) < p_in);
            bus0.in_data = 8'($urandom_range(0, 255));
            bus0.out_ready = ($urandom_range(0, 99) >= p_in - 15);
            bus1.in_valid = ($urandom_range(0, 99) < p_in);
            bus1.in_data = 8'($urandom_range(0, 255));
            bus1.out_ready = ($urandom_range(0, 99) >= p_in - 15);
            #2;
            model_cycle();
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
